// File: rtl/ddc_edid_reader.sv
// DDC/I2C initiator that reads a block of EDID bytes from the sink EEPROM
// and streams each received byte out with a one-cycle strobe.
module ddc_edid_reader #(
    parameter int         CLK_DIV   = 625,
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         NUM_BYTES = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] start_addr,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic [7:0] rd_index,
    output logic       rd_valid,
    output logic       done,
    output logic       nack_err
);

    localparam int            QW   = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);
    localparam logic [7:0]    LAST = 8'(NUM_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_TX,
        S_TACK,
        S_RSTART,
        S_RX,
        S_MACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [2:0]    q;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic [7:0]    addr;
    logic [1:0]    sel;
    logic          nack;
    logic          last;
    logic          sda_nxt;
    logic          sda_upd;
    logic          run;
    logic          stretch;
    logic          tick;

    assign run     = (state != S_IDLE) && (state != S_DONE);
    assign stretch = !scl_oe && !scl_in;
    assign tick    = run && !stretch && (qcnt == QMAX);

    // Counter restarts while SCL is released but still held low by the target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt <= '0;
        end else if (!run || stretch || qcnt == QMAX) begin
            qcnt <= '0;
        end else begin
            qcnt <= qcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            q        <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            addr     <= '0;
            sel      <= '0;
            nack     <= 1'b0;
            last     <= 1'b0;
            sda_nxt  <= 1'b0;
            sda_upd  <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rd_data  <= '0;
            rd_index <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            nack_err <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (rd_valid) rd_index <= rd_index + 8'd1;
            // SDA moves one clk after SCL falls, giving the target hold time
            if (sda_upd) begin
                sda_oe  <= sda_nxt;
                sda_upd <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_START;
                        q        <= 3'd1;
                        busy     <= 1'b1;
                        nack     <= 1'b0;
                        nack_err <= 1'b0;
                        rd_index <= '0;
                        addr     <= start_addr;
                        shreg    <= {DEV_ADDR, 1'b0};
                        sel      <= 2'd0;
                    end
                end
                S_START, S_RSTART: begin
                    if (tick) begin
                        if (q == 3'd4) begin
                            state   <= S_TX;
                            q       <= 3'd0;
                            bitcnt  <= 3'd0;
                            sda_nxt <= ~shreg[7];
                            sda_upd <= 1'b1;
                        end else begin
                            q <= q + 3'd1;
                            if (q == 3'd0) scl_oe <= 1'b0;
                            if (q == 3'd1) sda_oe <= 1'b1;
                            if (q == 3'd3) scl_oe <= 1'b1;
                        end
                    end
                end
                S_TX, S_TACK, S_RX, S_MACK: begin
                    if (tick) begin
                        unique case (q)
                            3'd0: q <= 3'd1;
                            3'd1: begin
                                q      <= 3'd2;
                                scl_oe <= 1'b0;
                            end
                            3'd2: begin
                                q <= 3'd3;
                                if (state == S_TACK) nack <= sda_in;
                                if (state == S_RX) begin
                                    shreg <= {shreg[6:0], sda_in};
                                    if (bitcnt == 3'd7) begin
                                        rd_data  <= {shreg[6:0], sda_in};
                                        rd_valid <= 1'b1;
                                        last     <= (rd_index == LAST);
                                    end
                                end
                            end
                            default: begin
                                q       <= 3'd0;
                                scl_oe  <= 1'b1;
                                sda_upd <= 1'b1;
                                unique case (state)
                                    S_TX: begin
                                        if (bitcnt == 3'd7) begin
                                            state   <= S_TACK;
                                            sda_nxt <= 1'b0;
                                        end else begin
                                            bitcnt  <= bitcnt + 3'd1;
                                            shreg   <= {shreg[6:0], 1'b0};
                                            sda_nxt <= ~shreg[6];
                                        end
                                    end
                                    S_TACK: begin
                                        if (nack) begin
                                            state   <= S_STOP;
                                            sda_nxt <= 1'b1;
                                        end else if (sel == 2'd0) begin
                                            state   <= S_TX;
                                            sel     <= 2'd1;
                                            shreg   <= addr;
                                            bitcnt  <= 3'd0;
                                            sda_nxt <= ~addr[7];
                                        end else if (sel == 2'd1) begin
                                            state   <= S_RSTART;
                                            sel     <= 2'd2;
                                            shreg   <= {DEV_ADDR, 1'b1};
                                            sda_nxt <= 1'b0;
                                        end else begin
                                            state   <= S_RX;
                                            bitcnt  <= 3'd0;
                                            sda_nxt <= 1'b0;
                                        end
                                    end
                                    S_RX: begin
                                        if (bitcnt == 3'd7) begin
                                            state   <= S_MACK;
                                            sda_nxt <= ~last;
                                        end else begin
                                            bitcnt  <= bitcnt + 3'd1;
                                            sda_nxt <= 1'b0;
                                        end
                                    end
                                    default: begin
                                        if (last) begin
                                            state   <= S_STOP;
                                            sda_nxt <= 1'b1;
                                        end else begin
                                            state   <= S_RX;
                                            bitcnt  <= 3'd0;
                                            sda_nxt <= 1'b0;
                                        end
                                    end
                                endcase
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (q == 3'd0) begin
                            q      <= 3'd1;
                            scl_oe <= 1'b0;
                        end else if (q == 3'd1) begin
                            q      <= 3'd2;
                            sda_oe <= 1'b0;
                        end else begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            nack_err <= nack;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
